// File: rtl/mw_writeback_pkg.sv
// mw_writeback_pkg
//   Shared definitions for the writeback stage: ISA opcode and ALU-op
//   encodings, the architectural special registers, the pending-entry record
//   used by the multdiv merge buffer, and the write-port source selector.
//   No ports (package).

package mw_writeback_pkg;

    // Pending buffer depth. The count is two bits wide, so this is fixed at 2.
    localparam int PEND_DEPTH_DEF = 2;

    // Architectural special registers.
    localparam logic [4:0] EXC_REG_DEF  = 5'd30;  // $rstatus
    localparam logic [4:0] LINK_REG_DEF = 5'd31;  // $ra

    // Opcodes, ir[31:27].
    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_SETX  = 5'b10101;

    // R-type ALU ops, ir[6:2], that complete in the multdiv unit.
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    // One pending multdiv result.
    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic [31:0] data;
    } pend_entry_t;

    // Which source owns the register-file write port this cycle.
    typedef enum logic [1:0] {
        PORT_IDLE   = 2'd0,
        PORT_PIPE   = 2'd1,
        PORT_DRAIN  = 2'd2,
        PORT_BYPASS = 2'd3
    } port_sel_t;

    // True when an R-type instruction's result is produced by the multdiv
    // unit rather than the ALU.
    function automatic logic is_multdiv(input logic [4:0] alu_op);
        return (alu_op == ALU_MUL) || (alu_op == ALU_DIV);
    endfunction

endpackage

// File: rtl/wb_pending_fifo.sv
// wb_pending_fifo
//   Two-entry in-order queue of multdiv results that could not use the
//   register-file write port in the cycle they arrived. Entries are kept
//   compacted: slot1 is only ever valid when slot0 is valid, so slot0 is
//   always the oldest entry (the head).
//
// Ports
//   clk        in   clock, rising edge
//   clr        in   asynchronous active-low clear; empties the queue
//   push       in   append {push_rd, push_data}; caller guarantees room
//                   after this cycle's pop
//   push_rd    in   destination register of the pushed entry
//   push_data  in   data of the pushed entry
//   pop        in   drop the head entry
//   squash     in   invalidate every stored entry whose rd equals squash_rd
//   squash_rd  in   register being overwritten by a younger write
//   head       out  oldest entry (valid bit qualifies rd/data)
//   count      out  number of stored entries, 0..2

module wb_pending_fifo
    import mw_writeback_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        push,
    input  logic [4:0]  push_rd,
    input  logic [31:0] push_data,
    input  logic        pop,
    input  logic        squash,
    input  logic [4:0]  squash_rd,
    output pend_entry_t head,
    output logic [1:0]  count
);

    pend_entry_t slot0_q, slot0_d;
    pend_entry_t slot1_q, slot1_d;

    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;

        // Squash first, so a squashed head never counts as occupying space.
        if (squash) begin
            if (slot0_d.valid && (slot0_d.rd == squash_rd)) begin
                slot0_d.valid = 1'b0;
            end
            if (slot1_d.valid && (slot1_d.rd == squash_rd)) begin
                slot1_d.valid = 1'b0;
            end
        end

        if (pop) begin
            slot0_d.valid = 1'b0;
        end

        // Re-compact: a hole at the head shifts the tail forward, keeping
        // FIFO order intact.
        if (!slot0_d.valid) begin
            slot0_d = slot1_d;
            slot1_d = '0;
        end

        if (push) begin
            if (!slot0_d.valid) begin
                slot0_d = '{valid: 1'b1, rd: push_rd, data: push_data};
            end else begin
                slot1_d = '{valid: 1'b1, rd: push_rd, data: push_data};
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            slot0_q <= '0;
            slot1_q <= '0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
        end
    end

    assign head  = slot0_q;
    assign count = {slot0_q.valid & slot1_q.valid, slot0_q.valid ^ slot1_q.valid};

endmodule

// File: rtl/mw_writeback.sv
// mw_writeback
//   Writeback stage. Decodes the M/W latch into a register-file write and
//   merges asynchronously completing multdiv results onto the same single
//   write port. Port priority: pipeline write, then pending-buffer head,
//   then a same-cycle multdiv bypass. A multdiv result that loses the port
//   is queued (up to 2); a pipeline write squashes queued results for the
//   same register so the younger value survives.
//
//   Flow control: md_valid is a one-cycle pulse with no ready. The producer
//   side (front end) must freeze while md_stall is high; a result that still
//   arrives while the buffer is full and nothing drains is dropped and
//   recorded in the sticky md_overflow flag.
//
// Ports
//   clk               in   pipeline clock, rising edge
//   clr               in   asynchronous active-low reset
//   ir_q              in   instruction in M/W
//   out               in   ALU/link/setx/exception-code value from M/W
//   data_mw           in   load data from M/W
//   exception_q       in   exception flag from M/W
//   md_valid          in   multdiv result ready (one-cycle pulse)
//   md_rd             in   multdiv destination register
//   md_result         in   multdiv result
//   ctrl_writeEnable  out  register-file write enable
//   ctrl_writeReg     out  register-file write address
//   data_writeReg     out  register-file write data
//   md_stall          out  pending buffer full
//   md_overflow       out  sticky: result dropped because the buffer was full

module mw_writeback
    import mw_writeback_pkg::*;
#(
    parameter int         PEND_DEPTH = PEND_DEPTH_DEF,
    parameter logic [4:0] EXC_REG    = EXC_REG_DEF,
    parameter logic [4:0] LINK_REG   = LINK_REG_DEF
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir_q,
    input  logic [31:0] out,
    input  logic [31:0] data_mw,
    input  logic        exception_q,
    input  logic        md_valid,
    input  logic [4:0]  md_rd,
    input  logic [31:0] md_result,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [31:0] data_writeReg,
    output logic        md_stall,
    output logic        md_overflow
);

    logic [4:0]  opcode;
    logic [4:0]  alu_op;
    logic        pipe_dec;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;

    logic        md_live;
    logic        drain;
    logic        enq_req;
    logic        push;
    logic        full;

    pend_entry_t head;
    logic [1:0]  count;
    port_sel_t   port_sel;

    logic        overflow_q, overflow_d;

    logic        unused_ir_bits;
    assign unused_ir_bits = ^{ir_q[21:7], ir_q[1:0]};

    assign opcode = ir_q[31:27];
    assign alu_op = ir_q[6:2];

    // ---------------------------------------------------------------- decode
    always_comb begin
        pipe_dec  = 1'b0;
        pipe_rd   = ir_q[26:22];
        pipe_data = out;
        case (opcode)
            OP_RTYPE: pipe_dec = !is_multdiv(alu_op);
            OP_ADDI:  pipe_dec = 1'b1;
            OP_LW: begin
                pipe_dec  = 1'b1;
                pipe_data = data_mw;
            end
            OP_JAL: begin
                pipe_dec = 1'b1;
                pipe_rd  = LINK_REG;
            end
            OP_SETX: begin
                pipe_dec = 1'b1;
                pipe_rd  = EXC_REG;
            end
            default: pipe_dec = 1'b0;
        endcase
        // An exception replaces whatever the instruction would have written,
        // including instructions that normally write nothing.
        if (exception_q) begin
            pipe_dec  = 1'b1;
            pipe_rd   = EXC_REG;
            pipe_data = out;
        end
    end

    // A write to r0 is architecturally a no-op, so it does not take the port
    // and does not block a drain.
    assign pipe_we = pipe_dec && (pipe_rd != 5'd0);

    // ------------------------------------------------------- port priority
    assign md_live = md_valid && (md_rd != 5'd0);
    assign full    = (count == 2'(PEND_DEPTH));
    assign drain   = !pipe_we && head.valid;

    // A result only queues when it lost the port. If it targets the register
    // the pipeline is writing right now it is older than that write and is
    // discarded along with any queued copies.
    assign enq_req = md_live && (pipe_we || drain) && !(pipe_we && (md_rd == pipe_rd));
    assign push    = enq_req && (!full || drain);

    always_comb begin
        port_sel = PORT_IDLE;
        if (pipe_we) begin
            port_sel = PORT_PIPE;
        end else if (head.valid) begin
            port_sel = PORT_DRAIN;
        end else if (md_live) begin
            port_sel = PORT_BYPASS;
        end
    end

    always_comb begin
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = 5'd0;
        data_writeReg    = 32'd0;
        case (port_sel)
            PORT_PIPE: begin
                ctrl_writeEnable = 1'b1;
                ctrl_writeReg    = pipe_rd;
                data_writeReg    = pipe_data;
            end
            PORT_DRAIN: begin
                ctrl_writeEnable = 1'b1;
                ctrl_writeReg    = head.rd;
                data_writeReg    = head.data;
            end
            PORT_BYPASS: begin
                ctrl_writeEnable = 1'b1;
                ctrl_writeReg    = md_rd;
                data_writeReg    = md_result;
            end
            default: ctrl_writeEnable = 1'b0;
        endcase
    end

    // -------------------------------------------------------- pending buffer
    wb_pending_fifo u_pending (
        .clk       (clk),
        .clr       (clr),
        .push      (push),
        .push_rd   (md_rd),
        .push_data (md_result),
        .pop       (drain),
        .squash    (pipe_we),
        .squash_rd (pipe_rd),
        .head      (head),
        .count     (count)
    );

    // ------------------------------------------------------------- overflow
    assign overflow_d = overflow_q || (enq_req && full && !drain);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign md_stall    = full;
    assign md_overflow = overflow_q;

endmodule

// File: tb/tb_mw_writeback.sv
module tb_mw_writeback;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] ir_q;
    logic [31:0] out_v;
    logic [31:0] data_mw;
    logic        exception_q;
    logic        md_valid;
    logic [4:0]  md_rd;
    logic [31:0] md_result;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic        md_stall;
    logic        md_overflow;

    int n_cmp = 0;
    int n_bad = 0;

    mw_writeback dut (
        .clk              (clk),
        .clr              (clr),
        .ir_q             (ir_q),
        .out              (out_v),
        .data_mw          (data_mw),
        .exception_q      (exception_q),
        .md_valid         (md_valid),
        .md_rd            (md_rd),
        .md_result        (md_result),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .md_stall         (md_stall),
        .md_overflow      (md_overflow)
    );

    // ---------------------------------------------------- clock / reset
    always #5 clk = ~clk;

    // ------------------------------------------------- reference model
    // Pending results as {rd, data}, oldest first.
    logic [36:0] exp_q[$];
    bit          m_ovf;
    bit          e_we;
    logic [4:0]  e_reg;
    logic [31:0] e_data;
    bit          e_stall;
    bit          e_ovf;

    function automatic void ref_decode(input logic [31:0] ir, input logic exc,
                                       output bit w, output logic [4:0] rd, output bit ld);
        logic [4:0] op;
        op = ir[31:27];
        w  = 0;
        ld = 0;
        rd = ir[26:22];
        if (exc) begin
            w  = 1;
            rd = 5'd30;
        end else if (op == 5'd0) begin
            w = (ir[6:2] != 5'd6) && (ir[6:2] != 5'd7);
        end else if (op == 5'd5) begin
            w = 1;
        end else if (op == 5'd8) begin
            w  = 1;
            ld = 1;
        end else if (op == 5'd3) begin
            w  = 1;
            rd = 5'd31;
        end else if (op == 5'd21) begin
            w  = 1;
            rd = 5'd30;
        end
        if (rd == 5'd0) w = 0;
    endfunction

    function automatic void model_eval();
        bit w, ld;
        logic [4:0] rd;
        ref_decode(ir_q, exception_q, w, rd, ld);
        e_stall = (exp_q.size() == 2);
        e_ovf   = m_ovf;
        e_we    = 1;
        if (w) begin
            e_reg  = rd;
            e_data = ld ? data_mw : out_v;
        end else if (exp_q.size() > 0) begin
            e_reg  = exp_q[0][36:32];
            e_data = exp_q[0][31:0];
        end else if (md_valid && md_rd != 5'd0) begin
            e_reg  = md_rd;
            e_data = md_result;
        end else begin
            e_we   = 0;
            e_reg  = 5'd0;
            e_data = 32'd0;
        end
    endfunction

    function automatic void model_commit();
        bit w, ld, drained;
        logic [4:0] rd;
        int start;
        logic [36:0] keep[$];
        ref_decode(ir_q, exception_q, w, rd, ld);
        start = exp_q.size();
        if (w) begin
            keep = {};
            foreach (exp_q[i]) if (exp_q[i][36:32] != rd) keep.push_back(exp_q[i]);
            exp_q = keep;
        end
        drained = !w && start > 0;
        if (drained) void'(exp_q.pop_front());
        if (md_valid && md_rd != 5'd0 && (w || drained) && !(w && md_rd == rd)) begin
            if (start == 2 && !drained) m_ovf = 1;
            else exp_q.push_back({md_rd, md_result});
        end
    endfunction

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            exp_q.delete();
            m_ovf = 0;
        end else begin
            model_commit();
        end
    end

    // --------------------------------------------------------- drivers
    function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] alu);
        return {5'b00000, rd, 15'd0, alu, 2'b00};
    endfunction

    function automatic logic [31:0] itype(input logic [4:0] op, input logic [4:0] rd);
        return {op, rd, 22'd0};
    endfunction

    // Inputs change on the falling edge; outputs are examined 1ns later.
    task automatic drive(input logic [31:0] ir, input logic [31:0] o, input logic [31:0] d,
                         input logic e, input logic mv, input logic [4:0] mr,
                         input logic [31:0] mres);
        @(negedge clk);
        ir_q        = ir;
        out_v       = o;
        data_mw     = d;
        exception_q = e;
        md_valid    = mv;
        md_rd       = mr;
        md_result   = mres;
        #1;
        model_eval();
    endtask

    task automatic idle();
        drive(32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    endtask

    // ----------------------------------------------------------- tests
    task automatic test_reset();
        #2;
        n_cmp++;
        if (ctrl_writeEnable !== 1'b0 || md_stall !== 1'b0 || md_overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: got we=%b stall=%b ovf=%b want 0/0/0",
                     ctrl_writeEnable, md_stall, md_overflow);
        end
        @(negedge clk);
        clr = 1'b1;
    endtask

    task automatic test_pipe_decode();
        logic [31:0] ir_v [7];
        logic [31:0] o_v  [7];
        logic        ex_v [7];
        bit          we_v [7];
        logic [4:0]  rg_v [7];
        logic [31:0] dt_v [7];
        ir_v = '{rtype(5'd3, 5'd0), itype(5'b01000, 5'd4), itype(5'b00101, 5'd0),
                 itype(5'b00111, 5'd9), rtype(5'd5, 5'd0), itype(5'b00011, 5'd0),
                 rtype(5'd7, 5'd6)};
        o_v  = '{32'h7, 32'h1234, 32'h55, 32'h66, 32'h2, 32'h100, 32'h99};
        ex_v = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        we_v = '{1, 1, 0, 0, 1, 1, 0};
        rg_v = '{5'd3, 5'd4, 5'd0, 5'd0, 5'd30, 5'd31, 5'd0};
        dt_v = '{32'h7, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h2, 32'h100, 32'h0};
        for (int i = 0; i < 7; i++) begin
            drive(ir_v[i], o_v[i], 32'hDEAD_BEEF, ex_v[i], 1'b0, 5'd0, 32'd0);
            n_cmp++;
            if (ctrl_writeEnable !== we_v[i] ||
                (we_v[i] && (ctrl_writeReg !== rg_v[i] || data_writeReg !== dt_v[i]))) begin
                n_bad++;
                $display("FAIL decode_%0d: got we=%b reg=%0d data=%h want we=%b reg=%0d data=%h",
                         i, ctrl_writeEnable, ctrl_writeReg, data_writeReg, we_v[i], rg_v[i], dt_v[i]);
            end
        end
        drive(itype(5'b10101, 5'd0), 32'h5, 32'h0, 1'b0, 1'b0, 5'd0, 32'd0);
        n_cmp++;
        if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd30 || data_writeReg !== 32'h5) begin
            n_bad++;
            $display("FAIL setx: got we=%b reg=%0d data=%h want 1/30/00000005",
                     ctrl_writeEnable, ctrl_writeReg, data_writeReg);
        end
    endtask

    task automatic test_bypass();
        drive(32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 5'd6, 32'h40);
        n_cmp++;
        if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd6 || data_writeReg !== 32'h40) begin
            n_bad++;
            $display("FAIL bypass: got we=%b reg=%0d data=%h want 1/6/00000040",
                     ctrl_writeEnable, ctrl_writeReg, data_writeReg);
        end
        idle();
        n_cmp++;
        if (ctrl_writeEnable !== 1'b0 || md_stall !== 1'b0) begin
            n_bad++;
            $display("FAIL bypass_empty: got we=%b stall=%b want 0/0", ctrl_writeEnable, md_stall);
        end
    endtask

    task automatic test_collide();
        drive(rtype(5'd3, 5'd0), 32'h7, 32'd0, 1'b0, 1'b1, 5'd6, 32'h40);
        n_cmp++;
        if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd3 || data_writeReg !== 32'h7) begin
            n_bad++;
            $display("FAIL collide_pipe: got we=%b reg=%0d data=%h want 1/3/00000007",
                     ctrl_writeEnable, ctrl_writeReg, data_writeReg);
        end
        idle();
        n_cmp++;
        if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd6 || data_writeReg !== 32'h40) begin
            n_bad++;
            $display("FAIL collide_drain: got we=%b reg=%0d data=%h want 1/6/00000040",
                     ctrl_writeEnable, ctrl_writeReg, data_writeReg);
        end
        idle();
        n_cmp++;
        if (ctrl_writeEnable !== 1'b0) begin
            n_bad++;
            $display("FAIL collide_after: got we=%b want 0", ctrl_writeEnable);
        end
    endtask

    task automatic test_squash();
        drive(itype(5'b00101, 5'd1), 32'h1, 32'd0, 1'b0, 1'b1, 5'd8, 32'h11);
        drive(itype(5'b00101, 5'd8), 32'h22, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        n_cmp++;
        if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd8 || data_writeReg !== 32'h22) begin
            n_bad++;
            $display("FAIL squash_pipe: got we=%b reg=%0d data=%h want 1/8/00000022",
                     ctrl_writeEnable, ctrl_writeReg, data_writeReg);
        end
        idle();
        n_cmp++;
        if (ctrl_writeEnable !== 1'b0) begin
            n_bad++;
            $display("FAIL squash_gone: got we=%b reg=%0d data=%h want we=0",
                     ctrl_writeEnable, ctrl_writeReg, data_writeReg);
        end
    endtask

    task automatic test_overflow();
        bit         st_v [7];
        bit         ov_v [7];
        bit         we_v [7];
        logic [4:0] rg_v [7];
        logic [31:0] dt_v [7];
        st_v = '{0, 0, 1, 1, 1, 0, 0};
        ov_v = '{0, 0, 0, 1, 1, 1, 1};
        we_v = '{1, 1, 1, 1, 1, 1, 0};
        rg_v = '{5'd1, 5'd2, 5'd9, 5'd13, 5'd10, 5'd11, 5'd0};
        dt_v = '{32'h1, 32'h2, 32'h9, 32'hD, 32'hA, 32'hB, 32'h0};
        for (int i = 0; i < 7; i++) begin
            if (i < 3)       drive(rtype(rg_v[i], 5'd0), dt_v[i], 32'd0, 1'b0, 1'b1,
                                   5'(10 + i), 32'(10 + i));
            else if (i == 3) drive(rtype(5'd13, 5'd0), 32'hD, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
            else             idle();
            n_cmp++;
            if (md_stall !== st_v[i] || md_overflow !== ov_v[i] || ctrl_writeEnable !== we_v[i] ||
                (we_v[i] && (ctrl_writeReg !== rg_v[i] || data_writeReg !== dt_v[i]))) begin
                n_bad++;
                $display("FAIL overflow_%0d: got stall=%b ovf=%b we=%b reg=%0d data=%h want %b/%b/%b/%0d/%h",
                         i, md_stall, md_overflow, ctrl_writeEnable, ctrl_writeReg, data_writeReg,
                         st_v[i], ov_v[i], we_v[i], rg_v[i], dt_v[i]);
            end
        end
    endtask

    task automatic test_clr();
        idle();
        clr = 1'b0;
        #1;
        n_cmp++;
        if (md_overflow !== 1'b0 || md_stall !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_ovf: got ovf=%b stall=%b want 0/0", md_overflow, md_stall);
        end
        @(negedge clk);
        clr = 1'b1;
        drive(rtype(5'd1, 5'd0), 32'h1, 32'd0, 1'b0, 1'b1, 5'd20, 32'h14);
        drive(rtype(5'd2, 5'd0), 32'h2, 32'd0, 1'b0, 1'b1, 5'd21, 32'h15);
        idle();
        n_cmp++;
        if (md_stall !== 1'b1 || ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd20) begin
            n_bad++;
            $display("FAIL clr_full: got stall=%b we=%b reg=%0d want 1/1/20",
                     md_stall, ctrl_writeEnable, ctrl_writeReg);
        end
        clr = 1'b0;
        #1;
        n_cmp++;
        if (md_stall !== 1'b0 || ctrl_writeEnable !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_mid: got stall=%b we=%b want 0/0", md_stall, ctrl_writeEnable);
        end
        @(negedge clk);
        clr = 1'b1;
        idle();
        n_cmp++;
        if (md_stall !== 1'b0 || ctrl_writeEnable !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_after: got stall=%b we=%b want 0/0", md_stall, ctrl_writeEnable);
        end
    endtask

    task automatic test_random();
        logic [31:0] ir;
        logic [4:0]  rd;
        for (int n = 0; n < 400; n++) begin
            rd = 5'($urandom_range(0, 12));
            case ($urandom_range(0, 9))
                0: ir = rtype(rd, 5'd0);
                1: ir = rtype(rd, 5'd6);
                2: ir = rtype(rd, 5'd7);
                3: ir = itype(5'b00101, rd);
                4: ir = itype(5'b01000, rd);
                5: ir = itype(5'b00111, rd);
                6: ir = itype(5'b00011, rd);
                7: ir = itype(5'b10101, rd);
                8: ir = itype(5'b00010, rd);
                default: ir = itype(5'b10110, rd);
            endcase
            ir[21:0] = ir[21:0] ^ (22'($urandom) & 22'h3F_FF83);
            drive(ir, $urandom, $urandom, ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 12)), $urandom);
            n_cmp++;
            if (ctrl_writeEnable !== e_we ||
                (e_we && (ctrl_writeReg !== e_reg || data_writeReg !== e_data))) begin
                n_bad++;
                $display("FAIL rand_port_%0d: got we=%b reg=%0d data=%h want we=%b reg=%0d data=%h",
                         n, ctrl_writeEnable, ctrl_writeReg, data_writeReg, e_we, e_reg, e_data);
            end
            n_cmp++;
            if (md_stall !== e_stall || md_overflow !== e_ovf) begin
                n_bad++;
                $display("FAIL rand_flags_%0d: got stall=%b ovf=%b want stall=%b ovf=%b",
                         n, md_stall, md_overflow, e_stall, e_ovf);
            end
            if (n == 200) begin
                clr = 1'b0;
                #1;
                @(negedge clk);
                clr = 1'b1;
            end
        end
    endtask

    // ----------------------------------------------------------- main
    initial begin
        clr         = 1'b0;
        ir_q        = 32'd0;
        out_v       = 32'd0;
        data_mw     = 32'd0;
        exception_q = 1'b0;
        md_valid    = 1'b0;
        md_rd       = 5'd0;
        md_result   = 32'd0;
        test_reset();
        test_pipe_decode();
        test_bypass();
        test_collide();
        test_squash();
        test_overflow();
        test_clr();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
